// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues sequential fetches to instruction memory,
// buffers in-order responses with their PCs and presents the head entry to ID.
module if_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   rsp_pc, rsp_pc_next;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] discard, discard_next;
  logic [AW-1:0] head, head_next;
  logic [AW-1:0] tail, tail_next;
  logic [CW:0]   occupancy;
  logic [31:0]   redirect_pc;
  logic          req_fire, push, pop;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  assign if_valid       = (count != '0);
  assign if_pc          = if_valid ? pc_mem[head] : 32'h0;
  assign if_instruction = if_valid ? instr_mem[head] : NOP_INSTR;
  assign redirect_pc    = flush_target & 32'hFFFF_FFFC;

  // Capacity counts in-flight fetches too, so a response always finds a free slot.
  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    rsp_pc_next    = rsp_pc;
    count_next     = count;
    inflight_next  = inflight;
    discard_next   = discard;
    head_next      = head;
    tail_next      = tail;
    occupancy      = {1'b0, count} + {1'b0, inflight};
    imem_req_valid = (state != IDLE) && !flush && (occupancy < DEPTH_W);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    pop            = if_valid && !stall && !flush;
    push           = imem_rsp_valid && !flush && (discard == '0);

    if (flush) begin
      fetch_pc_next = redirect_pc;
      rsp_pc_next   = redirect_pc;
      count_next    = '0;
      head_next     = '0;
      tail_next     = '0;
      inflight_next = inflight - CW'(imem_rsp_valid);
      discard_next  = inflight - CW'(imem_rsp_valid);
      state_next    = (discard_next != '0) ? DRAIN : FETCH;
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc + 32'd4;
      if (push) begin
        rsp_pc_next = rsp_pc + 32'd4;
        tail_next   = tail + AW'(1);
      end
      if (pop) head_next = head + AW'(1);
      count_next    = count + CW'(push) - CW'(pop);
      inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard != '0)) discard_next = discard - CW'(1);
      unique case (state)
        IDLE:    state_next = FETCH;
        FETCH:   state_next = FETCH;
        DRAIN:   if (discard_next == '0) state_next = FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      rsp_pc   <= rsp_pc_next;
      count    <= count_next;
      inflight <= inflight_next;
      discard  <= discard_next;
      head     <= head_next;
      tail     <= tail_next;
    end
  end

  // Storage needs no reset: entries are only visible while count says so.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[tail]    <= rsp_pc;
      instr_mem[tail] <= imem_rsp_data;
    end
  end

endmodule
